// File: rtl/shoot_pkg.sv
// Shared shoot-path definitions: debounce FSM states and default sizing.
package shoot_pkg;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    CONF_HI = 2'd1,
    HIGH    = 2'd2,
    CONF_LO = 2'd3
  } deb_state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEFAULT_CNT_W           = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous sensor pins.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/shoot_sense_debounce.sv
// Shoot-sensor conditioning: synchronise, debounce, edge strobes and a
// wrapping count of accepted rising edges.
module shoot_sense_debounce
  import shoot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             raw_in,
  input  logic             count_clr,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] event_count
);

  localparam int unsigned       STAB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
  localparam bit                DIRECT    = (DEBOUNCE_CYCLES == 1);

  logic              s2;
  deb_state_t        state;
  logic [STAB_W-1:0] stab_cnt;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (raw_in),
    .q       (s2)
  );

  // Debounce FSM; strobes default low and are raised only on acceptance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= LOW;
      stab_cnt    <= '0;
      level_out   <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      event_count <= '0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (count_clr) event_count <= '0;

      case (state)
        LOW: begin
          if (s2) begin
            if (DIRECT) begin
              state       <= HIGH;
              level_out   <= 1'b1;
              rise_pulse  <= 1'b1;
              event_count <= count_clr ? CNT_W'(1) : event_count + CNT_W'(1);
            end else begin
              state    <= CONF_HI;
              stab_cnt <= STAB_W'(1);
            end
          end
        end
        CONF_HI: begin
          if (!s2) begin
            state    <= LOW;
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state       <= HIGH;
            stab_cnt    <= '0;
            level_out   <= 1'b1;
            rise_pulse  <= 1'b1;
            event_count <= count_clr ? CNT_W'(1) : event_count + CNT_W'(1);
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end
        HIGH: begin
          if (!s2) begin
            if (DIRECT) begin
              state      <= LOW;
              level_out  <= 1'b0;
              fall_pulse <= 1'b1;
            end else begin
              state    <= CONF_LO;
              stab_cnt <= STAB_W'(1);
            end
          end
        end
        CONF_LO: begin
          if (s2) begin
            state    <= HIGH;
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state      <= LOW;
            stab_cnt   <= '0;
            level_out  <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end
        default: begin
          state    <= LOW;
          stab_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shoot_sense_debounce.sv
// Scoreboard bench: expected strobe events are queued by the stimulus and
// matched by per-instance monitors (DEBOUNCE_CYCLES=4 and =1, CNT_W=4).
module tb_shoot_sense_debounce;

  typedef struct {
    bit is_rise;
    int edge_no;
    int count;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       raw_a, raw_b, clr_a, clr_b;
  logic       lvl_a, rise_a, fall_a, lvl_b, rise_b, fall_b;
  logic [3:0] cnt_a, cnt_b;

  int  edge_n = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t q_a[$];
  ev_t q_b[$];

  shoot_sense_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_a), .count_clr(clr_a),
    .level_out(lvl_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .event_count(cnt_a)
  );

  shoot_sense_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_b), .count_clr(clr_b),
    .level_out(lvl_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .event_count(cnt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic push_a(input bit r, input int dly, input int c);
    ev_t e;
    e.is_rise = r; e.edge_no = edge_n + dly; e.count = c;
    q_a.push_back(e);
  endtask

  task automatic push_b(input bit r, input int dly, input int c);
    ev_t e;
    e.is_rise = r; e.edge_no = edge_n + dly; e.count = c;
    q_b.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitors: every strobe must match the head of its queue.
  always @(negedge clk) begin
    if (rise_a || fall_a) begin
      if (rise_a && fall_a) chk("a_both_strobes", 1, 0);
      if (q_a.size() == 0) chk("a_unexpected_strobe", int'(rise_a), int'(fall_a) + 2);
      else begin
        ev_t e;
        e = q_a.pop_front();
        chk("a_strobe_kind", int'(rise_a), int'(e.is_rise));
        chk("a_strobe_edge", edge_n, e.edge_no);
        chk("a_strobe_level", int'(lvl_a), int'(e.is_rise));
        chk("a_strobe_count", int'(cnt_a), e.count);
      end
    end
  end

  always @(negedge clk) begin
    if (rise_b || fall_b) begin
      if (rise_b && fall_b) chk("b_both_strobes", 1, 0);
      if (q_b.size() == 0) chk("b_unexpected_strobe", int'(rise_b), int'(fall_b) + 2);
      else begin
        ev_t e;
        e = q_b.pop_front();
        chk("b_strobe_kind", int'(rise_b), int'(e.is_rise));
        chk("b_strobe_edge", edge_n, e.edge_no);
        chk("b_strobe_level", int'(lvl_b), int'(e.is_rise));
        chk("b_strobe_count", int'(cnt_b), e.count);
      end
    end
  end

  initial begin
    reset_n = 1'b0; raw_a = 1'b0; raw_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    step(3);
    chk("reset_level", int'(lvl_a), 0);
    chk("reset_strobes", int'(rise_a | fall_a), 0);
    chk("reset_count", int'(cnt_a), 0);
    reset_n = 1'b1;
    step(2);

    // Clean rise: strobe at edge 6, gone at edge 7.
    raw_a = 1'b1; push_a(1'b1, 6, 1);
    step(6);
    chk("rise_level_e6", int'(lvl_a), 1);
    step(1);
    chk("rise_drop_e7", int'(rise_a), 0);
    step(3);

    // Two-sample low glitch from HIGH is ignored.
    raw_a = 1'b0; step(2); raw_a = 1'b1;
    step(8);
    chk("fall_glitch_level", int'(lvl_a), 1);
    raw_a = 1'b0; push_a(1'b0, 6, 1);
    step(8);
    chk("fall_level", int'(lvl_a), 0);
    chk("fall_count", int'(cnt_a), 1);

    // Three-sample high glitch from LOW is ignored.
    raw_a = 1'b1; step(3); raw_a = 1'b0;
    step(10);
    chk("glitch_level", int'(lvl_a), 0);
    chk("glitch_count", int'(cnt_a), 1);

    // Plain clear, then 17 edges: wrap to 0 at 16, then 1.
    clr_a = 1'b1; step(1); clr_a = 1'b0;
    chk("clr_count", int'(cnt_a), 0);
    for (int i = 0; i < 17; i++) begin
      raw_a = 1'b1; push_a(1'b1, 6, (i + 1) % 16);
      step(8);
      raw_a = 1'b0; push_a(1'b0, 6, (i + 1) % 16);
      step(8);
      if (i == 15) chk("wrap_count", int'(cnt_a), 0);
    end
    chk("post_wrap_count", int'(cnt_a), 1);

    // Clear coincident with acceptance: clear then count gives 1.
    raw_a = 1'b1; push_a(1'b1, 6, 1);
    step(5); clr_a = 1'b1; step(1); clr_a = 1'b0;
    step(2);
    chk("clr_rise_count", int'(cnt_a), 1);

    // Abort a rise mid-confirmation with reset, then re-debounce.
    raw_a = 1'b0; push_a(1'b0, 6, 1);
    step(8);
    raw_a = 1'b1;
    step(4);
    reset_n = 1'b0;
    step(1);
    chk("midconf_reset_level", int'(lvl_a), 0);
    chk("midconf_reset_strobes", int'(rise_a | fall_a), 0);
    chk("midconf_reset_count", int'(cnt_a), 0);
    reset_n = 1'b1; push_a(1'b1, 6, 1);
    step(8);
    chk("rerise_level", int'(lvl_a), 1);

    // DEBOUNCE_CYCLES=1: three-edge latency, even a one-cycle pulse passes.
    raw_b = 1'b1; push_b(1'b1, 3, 1);
    step(5);
    chk("d1_level_hi", int'(lvl_b), 1);
    raw_b = 1'b0; push_b(1'b0, 3, 1);
    step(5);
    chk("d1_level_lo", int'(lvl_b), 0);
    raw_b = 1'b1; push_b(1'b1, 3, 2); push_b(1'b0, 4, 2);
    step(1); raw_b = 1'b0;
    step(6);
    chk("d1_count", int'(cnt_b), 2);

    step(4);
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shoot_sense_debounce.md
# shoot_sense_debounce

Conditions the raw shoot-sensor pin (ball/kick detect) before it reaches the CPU-readable shoot PIO input. It synchronises the asynchronous pin and debounces it with a four-state FSM. It drives a clean level into the PIO `in_port`, plus one-cycle edge strobes and a wrapping event counter for the firmware-side kick logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable synchronised samples required to accept a level change (1 ms at 50 MHz); legal range 1..65535.
- `CNT_W`, default 8: width of `event_count`.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  synchronous active-low reset, sampled on `clk`.
- `raw_in`  in  1  asynchronous sensor pin, active-high.
- `count_clr`  in  1  synchronous clear of `event_count`.
- `level_out`  out  1  debounced level; feeds the shoot PIO `in_port`.
- `rise_pulse`  out  1  one-cycle strobe when `level_out` goes 0→1.
- `fall_pulse`  out  1  one-cycle strobe when `level_out` goes 1→0.
- `event_count`  out  CNT_W  number of accepted rising edges, modulo 2^CNT_W.

## Operation
- Synchroniser: two flops, `raw_in` → `s1` → `s2`. Only `s2` drives the FSM.
- Stability counter `stab_cnt`: width `$clog2(DEBOUNCE_CYCLES+1)`, unsigned.
- FSM states and transitions:
  - LOW: `level_out`=0. If `s2`=1, go to CONF_HI with `stab_cnt`=1.
  - CONF_HI:
    - If `s2`=0, return to LOW and clear `stab_cnt`.
    - Else if `stab_cnt`==DEBOUNCE_CYCLES−1, go to HIGH and set `level_out`=1, `rise_pulse`=1.
    - Else increment `stab_cnt`.
  - HIGH: `level_out`=1. If `s2`=0, go to CONF_LO with `stab_cnt`=1.
  - CONF_LO: mirror of CONF_HI. On acceptance, go to LOW with `level_out`=0 and `fall_pulse`=1. If `s2`=1, abort to HIGH.
- DEBOUNCE_CYCLES=1: LOW/HIGH transition directly on the first differing `s2` sample. The CONF states are never entered.
- `level_out` changes only in LOW/HIGH transitions and never toggles inside a CONF state. Glitches shorter than DEBOUNCE_CYCLES samples produce no output activity.
- `event_count`:
  - Increments on each `rise_pulse`.
  - Wraps from 2^CNT_W−1 to 0.
  - If `count_clr` and `rise_pulse` occur in the same cycle, the result is 1: clear first, then count.
- `fall_pulse` does not affect the count.

## Timing
- Reset values: `s1`=`s2`=0, state LOW, `stab_cnt`=0, `level_out`=0, `rise_pulse`=0, `fall_pulse`=0, `event_count`=0.
- Latency: count the edge that first samples `raw_in`=1 into `s1` as edge 1. With `raw_in` held, `level_out` and `rise_pulse` are high after edge DEBOUNCE_CYCLES+2. Falling latency is identical.
- `rise_pulse`/`fall_pulse` are exactly one cycle wide and coincide with the `level_out` change. `level_out` has no extra register stage beyond the FSM.
- Reset asserted mid-CONF aborts the confirmation and emits no pulse.
- If `raw_in` is still high after reset release, the block sees a fresh 0→1 and debounces again. A `rise_pulse` follows and the count increments.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `shoot_pkg`: FSM state enum (LOW, CONF_HI, HIGH, CONF_LO) and the default `DEBOUNCE_CYCLES`/`CNT_W` constants, shared with other shoot-path blocks.
- Sub-module `sync_2ff`: generic two-flop synchroniser with synchronous active-low reset, reused for other sensor pins.
- Top level: FSM, `stab_cnt`, edge strobes, event counter.

## Test plan
Benches use DEBOUNCE_CYCLES=4, CNT_W=4.
- Reset, then `raw_in`=1 held: `level_out` and `rise_pulse` go high after edge 6. `rise_pulse` drops at edge 7. `event_count`=1.
- Glitch: `raw_in`=1 for 3 `s2` samples, then 0: `level_out` stays 0, no pulses, `event_count`=0, FSM back in LOW.
- From HIGH, `raw_in`=0 for 2 cycles then 1: no `fall_pulse`, FSM returns to HIGH. Then 0 held: `fall_pulse` at edge 6 after the fall, `event_count` unchanged.
- 16 clean rising edges: `event_count` wraps to 0. 17th edge: count=1. `count_clr` coincident with a `rise_pulse`: count=1.
- `reset_n`=0 during CONF_HI (`stab_cnt`=2): all outputs 0 on the next edge, no pulse. With `raw_in` still 1 after release: `rise_pulse` 6 edges after release.
- DEBOUNCE_CYCLES=1 build: `level_out` follows `raw_in` with 3-edge latency, one pulse per transition.
